// File: rtl/mac16_array.sv
// mac16_array: 16x16 INT8/INT4 dot-product array with optional VSQ scaling.
// Define MAC16_VSQ_EN to build the is_vsq scale path; otherwise results are raw dots.
module mac16_array (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [4223:0] a_vec,
    input  logic [263:0]  b_vec,
    input  logic          is_int8_mode,
    input  logic          is_int4_mode,
    input  logic          is_vsq,
    output logic [6143:0] latch_array_out
);

    localparam int ROWS  = 16;
    localparam int VEC_W = 264;
    localparam int ACC_W = 24;
    localparam int DOT_W = 22;

    function automatic logic signed [DOT_W-1:0] dot_fn(
        input logic [255:0] a,
        input logic [255:0] b,
        input logic         int8
    );
        logic signed [DOT_W-1:0] acc;
        logic signed [15:0]      p8;
        logic signed [7:0]       p4;
        acc = '0;
        if (int8) begin
            for (int e = 0; e < 32; e++) begin
                p8  = $signed(a[e*8 +: 8]) * $signed(b[e*8 +: 8]);
                acc = acc + {{6{p8[15]}}, p8};
            end
        end else begin
            for (int e = 0; e < 64; e++) begin
                p4  = $signed(a[e*4 +: 4]) * $signed(b[e*4 +: 4]);
                acc = acc + {{14{p4[7]}}, p4};
            end
        end
        return acc;
    endfunction

`ifdef MAC16_VSQ_EN
    function automatic logic [ACC_W-1:0] vsq_fn(
        input logic signed [DOT_W-1:0] d,
        input logic [7:0]              sa,
        input logic [7:0]              sb
    );
        logic signed [39:0] dx;
        logic signed [39:0] sax;
        logic signed [39:0] sbx;
        logic signed [39:0] p;
        logic signed [39:0] s;
        dx  = {{18{d[DOT_W-1]}}, d};
        sax = {32'd0, sa};
        sbx = {32'd0, sb};
        p   = dx * sax * sbx;
        s   = p >>> 8;
        if (s > 40'sd8388607)
            return 24'h7FFFFF;
        else if (s < -40'sd8388608)
            return 24'h800000;
        else
            return s[ACC_W-1:0];
    endfunction
`endif

    logic                    armed;
    logic [4:0]              ptr;
    logic                    capture;

    logic                    s0_valid;
    logic [3:0]              s0_slot;
    logic                    s0_int8;
    logic                    s0_vsq;
    logic [4223:0]           s0_a;
    logic [VEC_W-1:0]        s0_b;

    logic                    s1_valid;
    logic [3:0]              s1_slot;
    logic [ACC_W-1:0]        s1_res [ROWS];

    logic signed [DOT_W-1:0] dot_d [ROWS];
    logic [ACC_W-1:0]        res_d [ROWS];
    logic [ACC_W-1:0]        arr   [ROWS][ROWS];
    logic                    vsq_in;

    assign capture = armed & (is_int8_mode | is_int4_mode) & ~ptr[4];

`ifdef MAC16_VSQ_EN
    assign vsq_in = is_vsq;
`else
    // Scale bits and is_vsq feed no logic in this build.
    logic unused_scales;
    assign vsq_in = 1'b0;
    always_comb begin
        unused_scales = is_vsq ^ s0_vsq ^ (^s0_b[263:256]);
        for (int k = 0; k < ROWS; k++)
            unused_scales = unused_scales ^ (^s0_a[k*VEC_W+256 +: 8]);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            ptr      <= '0;
            s0_valid <= 1'b0;
            s0_slot  <= '0;
            s0_int8  <= 1'b0;
            s0_vsq   <= 1'b0;
            s0_a     <= '0;
            s0_b     <= '0;
        end else begin
            armed    <= 1'b1;
            s0_valid <= capture;
            if (capture) begin
                ptr     <= ptr + 5'd1;
                s0_slot <= ptr[3:0];
                s0_int8 <= is_int8_mode;
                s0_vsq  <= vsq_in;
                s0_a    <= a_vec;
                s0_b    <= b_vec;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < ROWS; k++) begin
            dot_d[k] = dot_fn(s0_a[k*VEC_W +: 256], s0_b[255:0], s0_int8);
            res_d[k] = {{2{dot_d[k][DOT_W-1]}}, dot_d[k]};
`ifdef MAC16_VSQ_EN
            if (s0_vsq)
                res_d[k] = vsq_fn(dot_d[k], s0_a[k*VEC_W+256 +: 8],
                                  s0_b[263:256]);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_slot  <= '0;
            for (int k = 0; k < ROWS; k++)
                s1_res[k] <= '0;
        end else begin
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_slot <= s0_slot;
                for (int k = 0; k < ROWS; k++)
                    s1_res[k] <= res_d[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ROWS; k++)
                for (int j = 0; j < ROWS; j++)
                    arr[k][j] <= '0;
        end else if (s1_valid) begin
            for (int k = 0; k < ROWS; k++)
                arr[k][s1_slot] <= s1_res[k];
        end
    end

    for (genvar k = 0; k < ROWS; k++) begin : g_row
        for (genvar j = 0; j < ROWS; j++) begin : g_col
            assign latch_array_out[k*384 + j*ACC_W +: ACC_W] = arr[k][j];
        end
    end

endmodule

// File: tb/tb_mac16_array.sv
// tb_mac16_array: directed-vector bench for mac16_array.
// Expected values follow MAC16_VSQ_EN when it is defined for the build.
module tb_mac16_array;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4223:0] a_vec;
    logic [263:0]  b_vec;
    logic          is_int8_mode;
    logic          is_int4_mode;
    logic          is_vsq;
    logic [6143:0] latch_array_out;

    int n_checks = 0;
    int n_fail   = 0;

    mac16_array dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .a_vec           (a_vec),
        .b_vec           (b_vec),
        .is_int8_mode    (is_int8_mode),
        .is_int4_mode    (is_int4_mode),
        .is_vsq          (is_vsq),
        .latch_array_out (latch_array_out)
    );

    always #5 clk = ~clk;

    function automatic logic [263:0] v8(input logic [7:0] e, input logic [7:0] s);
        logic [263:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) v[i*8 +: 8] = e;
        v[263:256] = s;
        return v;
    endfunction

    function automatic logic [263:0] v4(input logic [3:0] e, input logic [7:0] s);
        logic [263:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) v[i*4 +: 4] = e;
        v[263:256] = s;
        return v;
    endfunction

    function automatic logic [23:0] ent(input int k, input int j);
        return latch_array_out[k*384 + j*24 +: 24];
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        is_int8_mode = 1'b0;
        is_int4_mode = 1'b0;
        is_vsq = 1'b0;
        b_vec = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cap(input logic [263:0] b, input logic i8, input logic i4,
                       input logic vq);
        b_vec = b;
        is_int8_mode = i8;
        is_int4_mode = i4;
        is_vsq = vq;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        is_int8_mode = 1'b0;
        is_int4_mode = 1'b0;
        is_vsq = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_vec = {16{v8(8'd1, 8'd0)}};
        b_vec = v8(8'd5, 8'd0);
        is_int8_mode = 1'b1;
        is_int4_mode = 1'b0;
        is_vsq = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (latch_array_out !== '0) begin
            n_fail++;
            $display("FAIL reset_clear: nonzero bits=%0d required 0", $countones(latch_array_out));
        end
        rst_n = 1'b1;
        @(negedge clk);
        idle(6);
        n_checks++;
        if (latch_array_out !== '0) begin
            n_fail++;
            $display("FAIL arm_no_capture: slot0 row0=%h required 000000", ent(0, 0));
        end
    endtask

    task automatic test_int8_basic();
        apply_reset();
        a_vec = {16{v8(8'd1, 8'd0)}};
        for (int j = 0; j < 16; j++) cap(v8(j[7:0], 8'd0), 1'b1, 1'b0, 1'b0);
        idle(8);
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < 16; j++) begin
                logic [23:0] exp_v;
                exp_v = 24'(32 * j);
                n_checks++;
                if (ent(k, j) !== exp_v) begin
                    n_fail++;
                    $display("FAIL int8_basic(%0d,%0d): got %h required %h", k, j, ent(k, j), exp_v);
                end
            end
    endtask

    task automatic test_int8_extreme();
        apply_reset();
        a_vec = {16{v8(8'h80, 8'd0)}};
        cap(v8(8'h80, 8'd0), 1'b1, 1'b0, 1'b0);
        a_vec = {16{v8(8'h7F, 8'd0)}};
        cap(v8(8'h80, 8'd0), 1'b1, 1'b0, 1'b0);
        idle(4);
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (ent(k, 0) !== 24'h080000) begin
                n_fail++;
                $display("FAIL int8_neg_neg row%0d: got %h required 080000", k, ent(k, 0));
            end
            n_checks++;
            if (ent(k, 1) !== 24'hF81000) begin
                n_fail++;
                $display("FAIL int8_pos_neg row%0d: got %h required F81000", k, ent(k, 1));
            end
            n_checks++;
            if (ent(k, 2) !== 24'h000000) begin
                n_fail++;
                $display("FAIL int8_untouched row%0d: got %h required 000000", k, ent(k, 2));
            end
        end
    endtask

    task automatic test_int4();
        int          e;
        logic [23:0] exp_both;
        e = -120 * 119 * 32;
        exp_both = e[23:0];
        apply_reset();
        a_vec = {16{v4(4'h8, 8'd0)}};
        cap(v4(4'h7, 8'd0), 1'b0, 1'b1, 1'b0);
        cap(v4(4'h7, 8'd0), 1'b1, 1'b1, 1'b0);
        idle(4);
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (ent(k, 0) !== 24'hFFF200) begin
                n_fail++;
                $display("FAIL int4 row%0d: got %h required FFF200", k, ent(k, 0));
            end
            n_checks++;
            if (ent(k, 1) !== exp_both) begin
                n_fail++;
                $display("FAIL both_modes row%0d: got %h required %h", k, ent(k, 1), exp_both);
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        a_vec = {16{v8(8'd1, 8'd0)}};
        for (int j = 0; j < 20; j++) cap(v8(8'(j + 1), 8'd0), 1'b1, 1'b0, 1'b0);
        idle(8);
        for (int j = 0; j < 16; j++) begin
            n_checks++;
            if (ent(3, j) !== 24'(32 * (j + 1))) begin
                n_fail++;
                $display("FAIL overcapture slot%0d: got %h required %h", j, ent(3, j), 24'(32 * (j + 1)));
            end
        end
        for (int i = 0; i < 10; i++) cap(v8(8'd100, 8'd0), 1'b1, 1'b0, 1'b0);
        idle(4);
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < 16; j++) begin
                n_checks++;
                if (ent(k, j) !== 24'(32 * (j + 1))) begin
                    n_fail++;
                    $display("FAIL hold(%0d,%0d): got %h required %h", k, j, ent(k, j), 24'(32 * (j + 1)));
                end
            end
    endtask

    task automatic test_vsq();
        logic [23:0] exp0;
        logic [23:0] exp1;
`ifdef MAC16_VSQ_EN
        exp0 = 24'h7FFFFF;
        exp1 = 24'hFFFFFF;
`else
        exp0 = 24'h080000;
        exp1 = 24'hFFFFE0;
`endif
        apply_reset();
        a_vec = {16{v8(8'h80, 8'hFF)}};
        cap(v8(8'h80, 8'hFF), 1'b1, 1'b0, 1'b1);
        a_vec = {16{v8(8'h01, 8'd2)}};
        cap(v8(8'hFF, 8'd3), 1'b1, 1'b0, 1'b1);
        a_vec = {16{v8(8'h80, 8'hFF)}};
        cap(v8(8'h80, 8'hFF), 1'b1, 1'b0, 1'b0);
        idle(4);
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (ent(k, 0) !== exp0) begin
                n_fail++;
                $display("FAIL vsq_sat row%0d: got %h required %h", k, ent(k, 0), exp0);
            end
            n_checks++;
            if (ent(k, 1) !== exp1) begin
                n_fail++;
                $display("FAIL vsq_shift row%0d: got %h required %h", k, ent(k, 1), exp1);
            end
            n_checks++;
            if (ent(k, 2) !== 24'h080000) begin
                n_fail++;
                $display("FAIL vsq_off row%0d: got %h required 080000", k, ent(k, 2));
            end
        end
    endtask

    task automatic test_batch_reset();
        apply_reset();
        a_vec = {16{v8(8'd1, 8'd0)}};
        for (int i = 0; i < 3; i++) cap(v8(8'd3, 8'd0), 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (ent(0, 0) !== 24'd96) begin
            n_fail++;
            $display("FAIL batch1_slot0: got %h required %h", ent(0, 0), 24'd96);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (latch_array_out !== '0) begin
            n_fail++;
            $display("FAIL async_clear: slot0 row0=%h required 000000", ent(0, 0));
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (latch_array_out !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: slot0 row0=%h required 000000", ent(0, 0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        cap(v8(8'd9, 8'd0), 1'b1, 1'b0, 1'b0);
        idle(6);
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (ent(k, 0) !== 24'd288) begin
                n_fail++;
                $display("FAIL new_slot0 row%0d: got %h required %h", k, ent(k, 0), 24'd288);
            end
            n_checks++;
            if (ent(k, 1) !== 24'd0) begin
                n_fail++;
                $display("FAIL no_stale row%0d: got %h required 000000", k, ent(k, 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_int8_basic();
        test_int8_extreme();
        test_int4();
        test_saturation();
        test_vsq();
        test_batch_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
